mmio_master: RTL and testbench

Single-cycle-core-side initiator for the memory-mapped peripheral bus. It accepts one load/store request at a time from the core's memory stage over a valid/ready handshake and drives the peripheral select strobe, write flag, address, write data and byte strobes for exactly one cycle. It samples the peripheral's combinational read data and error flag in that cycle. It returns the result through a registered response with byte-lane extraction, sign/zero extension and error reporting. Peripherals such as the free-running timer sit on the far side of this block.

---
 rtl/mmio_master.sv | 154 +++++++++++++++
 tb/tb_mmio_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master.sv
// Single-outstanding load/store initiator onto the one-cycle peripheral bus.
// Latency: aligned access 2 cycles accept->resp_valid, misaligned 1 cycle (bus untouched).
// Backpressure: response registers hold until resp_ready; req_ready only in IDLE.
module mmio_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_error,
    output logic              cen,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    input  logic [63:0]       rdata,
    input  logic              error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              q_wr;
    logic              q_uns;
    logic [ADDR_W-1:0] q_addr;
    logic [1:0]        q_size;
    logic [63:0]       q_wdata;

    logic              misaligned;
    logic [2:0]        off;
    logic [63:0]       size_mask;
    logic [7:0]        strb_base;
    logic [63:0]       rd_shift;
    logic [63:0]       ld_data;
    logic              sx;

    assign off = q_addr[2:0];

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cen        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                cen       = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        size_mask = 64'hFF;
        strb_base = 8'h01;
        case (q_size)
            2'd0: begin size_mask = 64'h0000_0000_0000_00FF; strb_base = 8'h01; end
            2'd1: begin size_mask = 64'h0000_0000_0000_FFFF; strb_base = 8'h03; end
            2'd2: begin size_mask = 64'h0000_0000_FFFF_FFFF; strb_base = 8'h0F; end
            default: begin size_mask = 64'hFFFF_FFFF_FFFF_FFFF; strb_base = 8'hFF; end
        endcase
    end

    // Bus outputs decode from state so an async reset clears them without a clock.
    assign wr    = cen & q_wr;
    assign addr  = cen ? q_addr : '0;
    assign wstrb = wr ? (strb_base << off) : 8'h00;
    assign wdata = wr ? ((q_wdata & size_mask) << {off, 3'b000}) : 64'h0;

    assign rd_shift = rdata >> {off, 3'b000};

    always_comb begin
        ld_data = rd_shift;
        sx      = 1'b0;
        case (q_size)
            2'd0: begin
                sx      = ~q_uns & rd_shift[7];
                ld_data = {{56{sx}}, rd_shift[7:0]};
            end
            2'd1: begin
                sx      = ~q_uns & rd_shift[15];
                ld_data = {{48{sx}}, rd_shift[15:0]};
            end
            2'd2: begin
                sx      = ~q_uns & rd_shift[31];
                ld_data = {{32{sx}}, rd_shift[31:0]};
            end
            default: ld_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_wr       <= 1'b0;
            q_uns      <= 1'b0;
            q_addr     <= '0;
            q_size     <= 2'd0;
            q_wdata    <= 64'h0;
            resp_rdata <= 64'h0;
            resp_error <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            q_wr    <= req_wr;
            q_uns   <= req_unsigned;
            q_addr  <= req_addr;
            q_size  <= req_size;
            q_wdata <= req_wdata;
            if (misaligned) begin
                resp_rdata <= 64'h0;
                resp_error <= 1'b1;
            end
        end else if (state == ACCESS) begin
            resp_error <= error;
            resp_rdata <= (error || q_wr) ? 64'h0 : ld_data;
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// Randomized and directed bench for mmio_master against a transaction-level timeline model.
module tb_mmio_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_wdata = 64'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        cen;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata = 64'h0;
    logic        error = 1'b0;

    always #5 clk = ~clk;

    mmio_master #(.ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .cen(cen), .wr(wr), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .error(error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the access rules.
    function automatic logic [63:0] m_mask(input logic [1:0] sz);
        if (sz == 2'd3) return '1;
        return (64'd1 << (8 * (1 << sz))) - 64'd1;
    endfunction

    function automatic logic m_aligned(input logic [1:0] sz, input logic [2:0] a);
        logic [2:0] lowmask;
        lowmask = 3'((1 << sz) - 1);
        return (a & lowmask) == 3'd0;
    endfunction

    function automatic logic [7:0] m_strb(input logic [1:0] sz, input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << (1 << sz)) - 16'd1) << off;
        return m[7:0];
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input logic [1:0] sz, input logic [2:0] off);
        return (d & m_mask(sz)) << (8 * off);
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
        logic [63:0] v;
        int n;
        v = (rd >> (8 * off)) & m_mask(sz);
        n = 8 * (1 << sz);
        if (!uns && sz != 2'd3 && v[n-1]) v = v | ~m_mask(sz);
        return v;
    endfunction

    // Peripheral and response-consumer stimulus modes.
    bit          rd_rand = 1'b0;
    logic [63:0] rd_fixed = 64'h8877_6655_4433_2211;
    bit          err_fixed = 1'b0;
    int          rr_mode = 1;
    int          hold = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdata = rd_rand ? {$urandom, $urandom} : rd_fixed;
            error = rd_rand ? ($urandom_range(0, 7) == 0) : err_fixed;
            case (rr_mode)
                0: resp_ready = 1'($urandom % 2);
                1: resp_ready = 1'b1;
                default: begin
                    if (!resp_valid) begin
                        hold = 0;
                        resp_ready = 1'b0;
                    end else if (hold < 3) begin
                        hold++;
                        resp_ready = 1'b0;
                    end else begin
                        resp_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Timeline model: busy from accept until the cycle after the response handshake.
    int          cyc = 0;
    bit          busy = 1'b0;
    bit          in_resp = 1'b0;
    int          acc_cyc = -1;
    int          resp_cyc = -1;
    int          acc_at = 0;
    logic        mq_wr;
    logic [31:0] mq_addr;
    logic [1:0]  mq_size;
    logic        mq_uns;
    logic [63:0] mq_wdata;
    logic [63:0] exp_rdata = 64'h0;
    logic        exp_err = 1'b0;
    int          last_lat = 0;
    int          cen_cnt = 0;
    int          resp_len = 0;
    logic [7:0]  last_wstrb = 8'h0;
    logic [63:0] last_wdata = 64'h0;
    logic        last_wr = 1'b0;
    logic [63:0] last_rdata = 64'h0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (!rstn) begin
            busy = 1'b0; in_resp = 1'b0; acc_cyc = -1; resp_cyc = -1;
        end else begin
            cyc++;
            if (resp_cyc == cyc) in_resp = 1'b1;
            chk("req_ready", req_ready, !busy);
            chk("resp_valid", resp_valid, in_resp);
            chk("cen", cen, acc_cyc == cyc);
            if (acc_cyc == cyc) begin
                chk("bus_wr", wr, mq_wr);
                chk("bus_addr", addr, mq_addr);
                chk("bus_wstrb", wstrb, mq_wr ? m_strb(mq_size, mq_addr[2:0]) : 8'h00);
                chk("bus_wdata", wdata, mq_wr ? m_wdata(mq_wdata, mq_size, mq_addr[2:0]) : 64'h0);
                exp_err   = error;
                exp_rdata = (error || mq_wr) ? 64'h0 : m_load(rdata, mq_addr[2:0], mq_size, mq_uns);
            end else begin
                chk("bus_idle", {wr, addr, wdata, wstrb}, 64'h0);
            end
            if (cen) begin
                cen_cnt++; last_wstrb = wstrb; last_wdata = wdata; last_wr = wr;
            end
            if (resp_valid) begin
                if (resp_len == 0) last_lat = cyc - acc_at;
                resp_len++;
                last_rdata = resp_rdata; last_err = resp_error;
            end
            if (in_resp) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_error", resp_error, exp_err);
            end
            if (in_resp && resp_ready) begin
                in_resp = 1'b0; busy = 1'b0; resp_cyc = -1;
            end else if (!busy && req_valid) begin
                busy = 1'b1;
                mq_wr = req_wr; mq_addr = req_addr; mq_size = req_size;
                mq_uns = req_unsigned; mq_wdata = req_wdata;
                acc_at = cyc; cen_cnt = 0; resp_len = 0;
                if (!m_aligned(req_size, req_addr[2:0])) begin
                    exp_rdata = 64'h0; exp_err = 1'b1; resp_cyc = cyc + 1;
                end else begin
                    acc_cyc = cyc + 1; resp_cyc = cyc + 2;
                end
            end
        end
    end

    task automatic run(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [63:0] d);
        int t;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_wr = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = d;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready && t < 50);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(resp_valid && resp_ready) && t < 50);
        chk("handshake", resp_valid && resp_ready, 1'b1);
        #1;
    endtask

    initial begin
        int t;
        chk("model_ld_sb7", m_load(64'h8877_6655_4433_2211, 3'd7, 2'd0, 1'b0), 64'hFFFF_FFFF_FFFF_FF88);
        chk("model_ld_uw4", m_load(64'h8877_6655_4433_2211, 3'd4, 2'd2, 1'b1), 64'h0000_0000_8877_6655);
        chk("model_strb_h6", m_strb(2'd1, 3'd6), 8'hC0);
        chk("model_wd_h6", m_wdata(64'h1234_ABCD, 2'd1, 3'd6), 64'hABCD_0000_0000_0000);

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_resp_rdata", resp_rdata, 64'h0);
        chk("rst_resp_error", resp_error, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);

        run(1'b0, 32'h0200_0000, 2'd3, 1'b0, 64'h0);
        chk("dword_rdata", last_rdata, 64'h8877_6655_4433_2211);
        chk("dword_err", last_err, 1'b0);
        chk("dword_lat", last_lat, 2);
        chk("dword_cen_cnt", cen_cnt, 1);
        run(1'b0, 32'h0200_0007, 2'd0, 1'b0, 64'h0);
        chk("sbyte7", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
        run(1'b0, 32'h0200_0007, 2'd0, 1'b1, 64'h0);
        chk("ubyte7", last_rdata, 64'h0000_0000_0000_0088);
        run(1'b0, 32'h0200_0002, 2'd1, 1'b0, 64'h0);
        chk("shalf2", last_rdata, 64'h0000_0000_0000_4433);
        run(1'b0, 32'h0200_0004, 2'd2, 1'b1, 64'h0);
        chk("uword4", last_rdata, 64'h0000_0000_8877_6655);

        err_fixed = 1'b1;
        run(1'b1, 32'h0200_0006, 2'd1, 1'b0, 64'hABCD);
        err_fixed = 1'b0;
        chk("st_wr", last_wr, 1'b1);
        chk("st_wstrb", last_wstrb, 8'hC0);
        chk("st_wdata", last_wdata, 64'hABCD_0000_0000_0000);
        chk("st_err", last_err, 1'b1);
        chk("st_rdata", last_rdata, 64'h0);

        run(1'b0, 32'h0200_0002, 2'd2, 1'b0, 64'h0);
        chk("mis_cen_cnt", cen_cnt, 0);
        chk("mis_lat", last_lat, 1);
        chk("mis_err", last_err, 1'b1);
        chk("mis_rdata", last_rdata, 64'h0);

        rr_mode = 2;
        run(1'b0, 32'h0200_0010, 2'd3, 1'b0, 64'h0);
        chk("bp_resp_len", resp_len, 4);
        chk("bp_rdata", last_rdata, 64'h8877_6655_4433_2211);
        rr_mode = 1;

        @(posedge clk);
        #1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0200_0008; req_size = 2'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_cen_before", cen, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_cen", cen, 1'b0);
        chk("arst_resp_valid", resp_valid, 1'b0);
        chk("arst_req_ready", req_ready, 1'b1);
        chk("arst_bus", {wr, addr, wdata, wstrb}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", resp_valid, 1'b0);
        end

        rd_rand = 1'b1;
        rr_mode = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b1;
            req_wr = 1'($urandom % 2);
            req_size = 2'($urandom % 4);
            req_addr = $urandom;
            if ($urandom % 4 != 0) req_addr = req_addr & ~32'((1 << req_size) - 1);
            req_unsigned = 1'($urandom % 2);
            req_wdata = {$urandom, $urandom};
            t = 0;
            do begin @(negedge clk); t++; end while (!req_ready && t < 50);
            if (t >= 50) chk("accept_timeout", req_ready, 1'b1);
            if ($urandom % 2 != 0) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                repeat ($urandom % 3) @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
